// File: rtl/delay_pkg.sv
// Shared constants and FSM state type for the programmable delay line.
package delay_pkg;
  localparam int unsigned DELAY_WIDTH = 8;
  localparam int unsigned DELAY_DEPTH = 16;
  localparam int unsigned DLY_W       = 4;

  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } delay_state_t;
endpackage

// File: rtl/delay_prog_mem.sv
// Ring-buffer storage: one synchronous write port, one asynchronous read port, no reset.
module delay_prog_mem #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/delay_prog_8.sv
// Programmable sample delay line (1..DEPTH-1 enabled edges) with fill gating.
// Macro DELAY_PROG_PRESET_EN makes the reset/fill value of q all ones instead of all zeros.
module delay_prog_8
  import delay_pkg::*;
#(
  parameter int unsigned WIDTH = DELAY_WIDTH,
  parameter int unsigned DEPTH = DELAY_DEPTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [WIDTH-1:0]         signal,
  input  logic                     en,
  input  logic [$clog2(DEPTH)-1:0] dly,
  output logic [WIDTH-1:0]         q,
  output logic                     q_valid
);
  localparam int unsigned AW = (DEPTH == DELAY_DEPTH) ? DLY_W : $clog2(DEPTH);
  localparam logic [AW-1:0] FILL_MAX = AW'(DEPTH - 1);

`ifdef DELAY_PROG_PRESET_EN
  localparam logic [WIDTH-1:0] GATE = '1;
`else
  localparam logic [WIDTH-1:0] GATE = '0;
`endif

  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    fill_cnt;
  logic [AW-1:0]    dly_q;
  delay_state_t     state;

  logic [AW-1:0]    n_eff;
  logic [AW-1:0]    rd_addr;
  logic [WIDTH-1:0] rd_data;
  logic [WIDTH-1:0] delayed;
  logic [AW:0]      fill_inc;
  logic             reach;

  // N=1 must behave as a plain flop, so the current input bypasses the buffer.
  always_comb begin
    n_eff    = (dly_q == '0) ? AW'(1) : dly_q;
    rd_addr  = wr_ptr - (n_eff - AW'(1));
    delayed  = (n_eff == AW'(1)) ? signal : rd_data;
    fill_inc = {1'b0, fill_cnt} + (AW+1)'(1);
    reach    = (fill_inc >= {1'b0, n_eff});
  end

  delay_prog_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (en),
    .waddr (wr_ptr),
    .wdata (signal),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      fill_cnt <= '0;
      dly_q    <= dly;
      state    <= FILL;
      q        <= GATE;
      q_valid  <= 1'b0;
    end else begin
      if (en) wr_ptr <= wr_ptr + AW'(1);
      // A delay change restarts output gating only; buffer history is kept.
      if (dly != dly_q) begin
        dly_q    <= dly;
        fill_cnt <= en ? AW'(1) : '0;
        state    <= FILL;
        q        <= GATE;
        q_valid  <= 1'b0;
      end else if (en) begin
        case (state)
          FILL: begin
            if (reach) begin
              state   <= RUN;
              q       <= delayed;
              q_valid <= 1'b1;
            end else if (fill_cnt != FILL_MAX) begin
              fill_cnt <= fill_cnt + AW'(1);
            end
          end
          RUN: begin
            q       <= delayed;
            q_valid <= 1'b1;
          end
          default: state <= FILL;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_delay_prog_8.sv
// Self-checking bench for delay_prog_8 against a history-queue reference model.
module tb_delay_prog_8;
  import delay_pkg::*;

`ifdef DELAY_PROG_PRESET_EN
  localparam logic [7:0] GATE = 8'hFF;
`else
  localparam logic [7:0] GATE = 8'h00;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic [7:0]       signal;
  logic             en;
  logic [DLY_W-1:0] dly;
  logic [7:0]       q;
  logic             q_valid;

  int checks = 0;
  int errors = 0;

  // Reference model: every written sample, count of enabled edges since restart.
  logic [7:0] hist[$];
  int         since;
  int         dly_m;
  logic [7:0] q_m;
  logic       v_m;

  delay_prog_8 #(.WIDTH(8), .DEPTH(16)) dut (
    .clk     (clk),
    .reset   (reset),
    .signal  (signal),
    .en      (en),
    .dly     (dly),
    .q       (q),
    .q_valid (q_valid)
  );

  always #5 clk = ~clk;

  task automatic model_update();
    int n;
    if (reset) begin
      hist.delete();
      since = 0;
      dly_m = int'(dly);
      q_m   = GATE;
      v_m   = 1'b0;
    end else begin
      n = (dly_m == 0) ? 1 : dly_m;
      if (int'(dly) != dly_m) begin
        if (en) hist.push_back(signal);
        dly_m = int'(dly);
        since = en ? 1 : 0;
        q_m   = GATE;
        v_m   = 1'b0;
      end else if (en) begin
        hist.push_back(signal);
        since++;
        if (since >= n) begin
          q_m = hist[hist.size() - n];
          v_m = 1'b1;
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic do_reset(input int d);
    reset = 1'b1; en = 1'b0; dly = DLY_W'(d); signal = 8'h00;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; en = 1'b1; dly = 4'd7; signal = 8'h5A;
    tick();
    checks++;
    if (q !== GATE || q_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset: q=%h q_valid=%b required q=%h q_valid=0", q, q_valid, GATE);
    end
    reset = 1'b0;
  endtask

  task automatic test_dly3();
    do_reset(3);
    en = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      signal = 8'(i);
      tick();
      checks++;
      if (i < 3) begin
        if (q !== GATE || q_valid !== 1'b0) begin
          errors++;
          $display("FAIL dly3 edge %0d: q=%h q_valid=%b required q=%h q_valid=0", i, q, q_valid, GATE);
        end
      end else if (q !== 8'(i - 2) || q_valid !== 1'b1) begin
        errors++;
        $display("FAIL dly3 edge %0d: q=%h q_valid=%b required q=%h q_valid=1", i, q, q_valid, 8'(i - 2));
      end
    end
  endtask

  task automatic test_dly0_vs_1();
    logic [7:0] sig[20];
    logic [7:0] qa[20];
    logic       va[20];
    for (int i = 0; i < 20; i++) sig[i] = 8'($urandom);
    do_reset(0);
    en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      signal = sig[i];
      tick();
      qa[i] = q; va[i] = q_valid;
      checks++;
      if (q !== sig[i] || q_valid !== 1'b1) begin
        errors++;
        $display("FAIL dly0 edge %0d: q=%h q_valid=%b required q=%h q_valid=1", i, q, q_valid, sig[i]);
      end
    end
    do_reset(1);
    en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      signal = sig[i];
      tick();
      checks++;
      if (q !== qa[i] || q_valid !== va[i] || q !== q_m || q_valid !== v_m) begin
        errors++;
        $display("FAIL dly1_vs_0 edge %0d: q=%h q_valid=%b required q=%h q_valid=%b", i, q, q_valid, q_m, v_m);
      end
    end
  endtask

  task automatic test_wrap();
    do_reset(15);
    en = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      signal = 8'(i);
      tick();
      checks++;
      if (i >= 15 && (q !== 8'(i - 14) || q_valid !== 1'b1)) begin
        errors++;
        $display("FAIL wrap edge %0d: q=%h q_valid=%b required q=%h q_valid=1", i, q, q_valid, 8'(i - 14));
      end else if (i < 15 && (q !== GATE || q_valid !== 1'b0)) begin
        errors++;
        $display("FAIL wrap fill edge %0d: q=%h q_valid=%b required q=%h q_valid=0", i, q, q_valid, GATE);
      end
    end
  endtask

  task automatic test_stall();
    logic [7:0] q_hold;
    logic       v_hold;
    do_reset(4);
    en = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      signal = 8'(i);
      tick();
    end
    q_hold = q; v_hold = q_valid;
    checks++;
    if (q !== 8'd5 || q_valid !== 1'b1) begin
      errors++;
      $display("FAIL stall pre: q=%h q_valid=%b required q=05 q_valid=1", q, q_valid);
    end
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      signal = 8'($urandom);
      tick();
      checks++;
      if (q !== q_hold || q_valid !== v_hold) begin
        errors++;
        $display("FAIL stall hold %0d: q=%h q_valid=%b required q=%h q_valid=%b", i, q, q_valid, q_hold, v_hold);
      end
    end
    en = 1'b1;
    for (int i = 9; i <= 14; i++) begin
      signal = 8'(i);
      tick();
      checks++;
      if (q !== 8'(i - 3) || q_valid !== 1'b1) begin
        errors++;
        $display("FAIL stall resume edge %0d: q=%h q_valid=%b required q=%h q_valid=1", i, q, q_valid, 8'(i - 3));
      end
    end
  endtask

  task automatic test_dly_change();
    do_reset(4);
    en = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      signal = 8'(16 + i);
      tick();
    end
    dly = 4'd2; signal = 8'hC3;
    tick();
    checks++;
    if (q !== GATE || q_valid !== 1'b0) begin
      errors++;
      $display("FAIL dly_change gate: q=%h q_valid=%b required q=%h q_valid=0", q, q_valid, GATE);
    end
    signal = 8'h3C;
    tick();
    checks++;
    if (q !== 8'hC3 || q_valid !== 1'b1) begin
      errors++;
      $display("FAIL dly_change resume: q=%h q_valid=%b required q=c3 q_valid=1", q, q_valid);
    end
  endtask

  task automatic test_reset_mid();
    do_reset(5);
    en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      signal = 8'h80 | 8'(i);
      tick();
    end
    reset = 1'b1; signal = 8'hEE;
    tick();
    reset = 1'b0;
    checks++;
    if (q !== GATE || q_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: q=%h q_valid=%b required q=%h q_valid=0", q, q_valid, GATE);
    end
    for (int i = 0; i < 14; i++) begin
      signal = 8'($urandom_range(0, 127));
      tick();
      checks++;
      if ((q_valid === 1'b1 && q[7] !== 1'b0) || q !== q_m || q_valid !== v_m) begin
        errors++;
        $display("FAIL reset_mid refill %0d: q=%h q_valid=%b required q=%h q_valid=%b", i, q, q_valid, q_m, v_m);
      end
    end
  endtask

  task automatic test_random();
    do_reset(int'($urandom_range(0, 15)));
    for (int i = 0; i < 400; i++) begin
      en     = ($urandom_range(0, 3) != 0);
      signal = 8'($urandom);
      if ($urandom_range(0, 39) == 0) dly = DLY_W'($urandom_range(0, 15));
      reset  = ($urandom_range(0, 99) == 0);
      tick();
      checks++;
      if (q !== q_m || q_valid !== v_m) begin
        errors++;
        $display("FAIL random %0d: q=%h q_valid=%b required q=%h q_valid=%b", i, q, q_valid, q_m, v_m);
      end
    end
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; dly = '0; signal = '0;
    since = 0; dly_m = 0; q_m = GATE; v_m = 1'b0;
    test_reset();
    test_dly3();
    test_dly0_vs_1();
    test_wrap();
    test_stall();
    test_dly_change();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
